uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_tx.
REQ-002 Parameter DATA_BITS, default 8, width of one UART character.
REQ-003 Parameter WORD_BYTES, default 4, characters per requester word.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester word-pending flag.
REQ-007 req_data  input  NUM_REQ*WORD_BYTES*DATA_BITS  requester i word at slice i, LSB byte first.
REQ-008 req_ready  output  NUM_REQ  one-cycle accept pulse, at most one bit high.
REQ-009 tx_done_tick  input  1  end-of-character pulse from uart_tx.
REQ-010 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-011 tx_din  output  DATA_BITS  character to uart_tx, stable from tx_start until tx_done_tick.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the requester being served; holds last value in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, [HEADER, HWAIT], SEND, WAIT.
REQ-015 IDLE: any req_valid high -> GRANT next cycle; grant_id registers the round-robin winner.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ; after reset last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-017 GRANT: req_ready[grant_id] high for exactly that cycle; req_data slice captured into a shift register on the same edge; byte counter cleared.
REQ-018 Requesters SHALL hold req_valid and req_data stable until their req_ready pulse; a valid that drops before GRANT is not served, and no acceptance occurs.
REQ-019 SEND: tx_start high one cycle, tx_din = shift register low byte; next state WAIT.
REQ-020 WAIT: on tx_done_tick, shift register shifts right by DATA_BITS and counter increments; if counter was WORD_BYTES-1 -> IDLE and last_grant = grant_id, else -> SEND.
REQ-021 tx_done_tick outside WAIT/HWAIT SHALL be ignored.
REQ-022 Latency: valid sampled in IDLE at cycle n -> req_ready at n+1 -> first tx_start at n+2 (no header).
REQ-023 Inter-character gap: tx_start SHALL assert exactly one cycle after each non-final tx_done_tick.
REQ-024 Requests arriving during busy SHALL wait; arbitration happens only in IDLE, after the word completes.

Reset
REQ-025 Reset SHALL force IDLE, req_ready=0, tx_start=0, tx_din=0, busy=0, grant_id=0, last_grant=NUM_REQ-1, counter and shift register cleared.
REQ-026 Reset mid-word SHALL abort the word without further tx_start; the partial word is lost.

Configuration
REQ-027 Macro UART_TX_SCHED_HEADER_EN defined: GRANT -> HEADER, which sends one character {0..., grant_id} with tx_start, then HWAIT on tx_done_tick -> SEND; frames are WORD_BYTES+1 characters.
REQ-028 Macro undefined: HEADER/HWAIT are absent, GRANT -> SEND directly, frames are WORD_BYTES characters.

Structure
REQ-029 State encodings and the macro default SHALL live in the shared uart header alongside the existing UART state definitions.
REQ-030 The round-robin winner logic SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs any, winner), purely combinational.

Verification
REQ-031 Single word: req_valid[2]=1, data 0x44332211 -> tx_din sequence 0x11,0x22,0x33,0x44; req_ready[2] one pulse; busy falls after the 4th done.
REQ-032 All four valid continuously -> grant order 0,1,2,3,0; no starvation.
REQ-033 Request 1 arrives during requester 0's word -> served only after the 4th tx_done_tick of requester 0.
REQ-034 Spurious tx_done_tick in IDLE and in SEND -> no state or counter change.
REQ-035 Reset asserted after the 2nd character -> outputs at reset values immediately; next grant goes to requester 0.
REQ-036 HEADER_EN, requester 3, data 0xDDCCBBAA -> tx_din 0x03,0xAA,0xBB,0xCC,0xDD.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared uart state encodings; UART_TX_SCHED_HEADER_EN adds the
// grant-id header states to the scheduler FSM.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
`ifdef UART_TX_SCHED_HEADER_EN
  typedef enum logic [2:0] {IDLE, GRANT, HEADER, HWAIT, SEND, WAIT} sched_state_t;
`else
  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT} sched_state_t;
`endif
endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner search starting after last_grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic          any,
  output logic [GW-1:0] winner
);
  assign any = |req;
  // walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    winner = '0;
    for (int i = N; i >= 1; i--)
      if (req[GW'((int'(last_grant) + i) % N)]) winner = GW'((int'(last_grant) + i) % N);
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding requester words to one uart_tx.
// Define UART_TX_SCHED_HEADER_EN to prefix each word with a grant-id character.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int WORD_BYTES = 4,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*WORD_BYTES*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 tx_done_tick,
  output logic                                 tx_start,
  output logic [DATA_BITS-1:0]                 tx_din,
  output logic                                 busy,
  output logic [GW-1:0]                        grant_id
);
  localparam int WW = WORD_BYTES * DATA_BITS;
  localparam int CW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  sched_state_t state;
  logic [GW-1:0] last_grant, winner;
  logic any;
  logic [CW-1:0] cnt;
  logic [WW-1:0] shift, word, shift_nx;
  rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_arb (
    .req(req_valid),
    .last_grant(last_grant),
    .any(any),
    .winner(winner)
  );
  assign word     = req_data[grant_id*WW +: WW];
  assign shift_nx = shift >> DATA_BITS;
  // a requester whose valid dropped before GRANT sees no accept pulse
  assign req_ready = (state == GRANT) ? req_valid & (NUM_REQ'(1) << grant_id) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_din     <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      cnt        <= '0;
      shift      <= '0;
    end else
      case (state)
        IDLE:
          if (any) begin
            state    <= GRANT;
            grant_id <= winner;
            busy     <= 1'b1;
          end
        GRANT:
          if (!req_valid[grant_id]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            shift    <= word;
            cnt      <= '0;
            tx_start <= 1'b1;
`ifdef UART_TX_SCHED_HEADER_EN
            state    <= HEADER;
            tx_din   <= DATA_BITS'(grant_id);
`else
            state    <= SEND;
            tx_din   <= word[DATA_BITS-1:0];
`endif
          end
`ifdef UART_TX_SCHED_HEADER_EN
        HEADER: begin
          tx_start <= 1'b0;
          state    <= HWAIT;
        end
        HWAIT:
          if (tx_done_tick) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_din   <= shift[DATA_BITS-1:0];
          end
`endif
        SEND: begin
          tx_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT:
          if (tx_done_tick) begin
            shift <= shift_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WORD_BYTES - 1)) begin
              state      <= IDLE;
              last_grant <= grant_id;
              busy       <= 1'b0;
            end else begin
              state    <= SEND;
              tx_start <= 1'b1;
              tx_din   <= shift_nx[DATA_BITS-1:0];
            end
          end
        default: state <= IDLE;
      endcase
endmodule
